// File: rtl/debug_halt_ctrl_pkg.sv
// Shared types and cause codes for the hart-side debug halt/resume sequencer.
package debug_halt_ctrl_pkg;

  typedef enum logic [2:0] {
    StRunning,
    StFlush,
    StDrain,
    StHalted,
    StResume,
    StStep
  } dbg_state_e;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  // ebreak outranks haltreq, which outranks a completed step.
  function automatic logic [2:0] halt_cause(input logic ebreak, input logic haltreq);
    if (ebreak) begin
      return CAUSE_EBREAK;
    end else if (haltreq) begin
      return CAUSE_HALTREQ;
    end
    return CAUSE_STEP;
  endfunction

endpackage

// File: rtl/debug_halt_ctrl_if.sv
// Signals between the debug halt sequencer and the DM/pipeline side.
interface debug_halt_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            haltreq;
  logic            resumereq;
  logic            ebreak_hit;
  logic            step_en;
  logic            retire_valid;
  logic [XLEN-1:0] halt_pc;
  logic            empty_core;
  logic            dpc_we;
  logic [XLEN-1:0] dpc_wdata;

  logic            debug_on;
  logic            flush_flag;
  logic            halted;
  logic            running;
  logic            resumeack;
  logic            redirect_vld;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] dpc;
  logic [2:0]      dcause;
  logic            halt_err;

  // DM and pipeline side.
  modport master (
    output haltreq, resumereq, ebreak_hit, step_en, retire_valid, halt_pc,
           empty_core, dpc_we, dpc_wdata,
    input  debug_on, flush_flag, halted, running, resumeack, redirect_vld,
           redirect_pc, dpc, dcause, halt_err
  );

  // Sequencer side.
  modport slave (
    input  haltreq, resumereq, ebreak_hit, step_en, retire_valid, halt_pc,
           empty_core, dpc_we, dpc_wdata,
    output debug_on, flush_flag, halted, running, resumeack, redirect_vld,
           redirect_pc, dpc, dcause, halt_err
  );

endinterface

// File: rtl/debug_halt_ctrl_drain_timer.sv
// Saturating drain-cycle counter; expired_o flags the last allowed drain cycle.
module debug_halt_ctrl_drain_timer #(
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned WIDTH = $clog2(DRAIN_TIMEOUT);
  localparam logic [WIDTH-1:0] LastCnt = WIDTH'(DRAIN_TIMEOUT - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/debug_halt_ctrl.sv
// Halt/resume sequencer: turns haltreq/ebreak/step into flush + drain, tracks
// halted/running, owns dpc/dcause and issues the resume redirect.
module debug_halt_ctrl
  import debug_halt_ctrl_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input logic               clk_i,
  input logic               rst_i,
  debug_halt_ctrl_if.slave  bus_io
);

  dbg_state_e      state_q, state_d;
  logic [XLEN-1:0] dpc_q, dpc_d;
  logic [2:0]      dcause_q, dcause_d;
  logic            step_q, step_d;
  logic            halt_err_q, halt_err_d;

  logic debug_on_q, flush_q, halted_q, running_q, resumeack_q, redirect_q;

  logic timer_clear, timer_en, timer_expired;

  debug_halt_ctrl_drain_timer #(
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) u_drain_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clear),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    dpc_d       = dpc_q;
    dcause_d    = dcause_q;
    step_d      = step_q;
    halt_err_d  = halt_err_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      StRunning: begin
        if (bus_io.ebreak_hit || bus_io.haltreq) begin
          state_d  = StFlush;
          dpc_d    = bus_io.halt_pc;
          dcause_d = halt_cause(bus_io.ebreak_hit, bus_io.haltreq);
        end
      end
      StFlush: begin
        state_d     = StDrain;
        timer_clear = 1'b1;
      end
      StDrain: begin
        timer_en = 1'b1;
        if (bus_io.empty_core) begin
          state_d = StHalted;
        end else if (timer_expired) begin
          state_d    = StHalted;
          halt_err_d = 1'b1;
        end
      end
      StHalted: begin
        if (bus_io.dpc_we) begin
          dpc_d = bus_io.dpc_wdata;
        end
        // A DM still asserting haltreq keeps the hart parked.
        if (bus_io.resumereq && !bus_io.haltreq) begin
          state_d = StResume;
          step_d  = bus_io.step_en;
        end
      end
      StResume: begin
        state_d = step_q ? StStep : StRunning;
      end
      StStep: begin
        if (bus_io.ebreak_hit || bus_io.haltreq || bus_io.retire_valid) begin
          state_d  = StFlush;
          dpc_d    = bus_io.halt_pc;
          dcause_d = halt_cause(bus_io.ebreak_hit, bus_io.haltreq);
        end
      end
      default: begin
        state_d = StRunning;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRunning;
      dpc_q       <= '0;
      dcause_q    <= CAUSE_NONE;
      step_q      <= 1'b0;
      halt_err_q  <= 1'b0;
      debug_on_q  <= 1'b0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
      running_q   <= 1'b1;
      resumeack_q <= 1'b0;
      redirect_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dpc_q       <= dpc_d;
      dcause_q    <= dcause_d;
      step_q      <= step_d;
      halt_err_q  <= halt_err_d;
      debug_on_q  <= (state_d == StFlush) || (state_d == StDrain) || (state_d == StHalted);
      flush_q     <= (state_d == StFlush);
      halted_q    <= (state_d == StHalted);
      running_q   <= (state_d == StRunning) || (state_d == StStep);
      resumeack_q <= (state_d == StResume);
      redirect_q  <= (state_d == StResume);
    end
  end

  assign bus_io.debug_on     = debug_on_q;
  assign bus_io.flush_flag   = flush_q;
  assign bus_io.halted       = halted_q;
  assign bus_io.running      = running_q;
  assign bus_io.resumeack    = resumeack_q;
  assign bus_io.redirect_vld = redirect_q;
  assign bus_io.redirect_pc  = dpc_q;
  assign bus_io.dpc          = dpc_q;
  assign bus_io.dcause       = dcause_q;
  assign bus_io.halt_err     = halt_err_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Scenario bench for debug_halt_ctrl with halt-record and redirect scoreboards.
module tb_debug_halt_ctrl;
  import debug_halt_ctrl_pkg::*;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned DRAIN_TIMEOUT = 64;

  typedef struct packed {
    logic [2:0]      cause;
    logic [XLEN-1:0] pc;
  } halt_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_halt_ctrl_if #(.XLEN(XLEN)) bus ();

  debug_halt_ctrl #(
    .XLEN         (XLEN),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  halt_exp_t       halt_q[$];
  logic [XLEN-1:0] redir_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int flush_pairs = 0;
  logic flush_prev = 1'b0;

  always @(posedge clk) begin
    if (bus.flush_flag && flush_prev) flush_pairs <= flush_pairs + 1;
    flush_prev <= bus.flush_flag;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.haltreq      = 1'b0;
    bus.resumereq    = 1'b0;
    bus.ebreak_hit   = 1'b0;
    bus.step_en      = 1'b0;
    bus.retire_valid = 1'b0;
    bus.halt_pc      = '0;
    bus.empty_core   = 1'b1;
    bus.dpc_we       = 1'b0;
    bus.dpc_wdata    = '0;
  endtask

  task automatic wait_halted(input int bound, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < bound && !ok) begin
      tick();
      cycles++;
      if (bus.halted === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pop_halt(output halt_exp_t e);
    if (halt_q.size() == 0) e = '{cause: 3'h7, pc: '1};
    else e = halt_q.pop_front();
  endtask

  task automatic do_resume(input logic step);
    bus.resumereq = 1'b1;
    bus.step_en   = step;
    tick();
    bus.resumereq = 1'b0;
    bus.step_en   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    n_cmp++;
    if (bus.running !== 1'b1) begin
      n_mis++; $display("FAIL reset_running: got %b expected 1", bus.running);
    end
    n_cmp++;
    if ({bus.debug_on, bus.flush_flag, bus.halted, bus.resumeack, bus.redirect_vld,
         bus.halt_err} !== 6'b0) begin
      n_mis++;
      $display("FAIL reset_flags: got %b expected 000000", {bus.debug_on, bus.flush_flag,
               bus.halted, bus.resumeack, bus.redirect_vld, bus.halt_err});
    end
    n_cmp++;
    if ({bus.dcause, bus.dpc} !== {3'd0, 32'h0}) begin
      n_mis++; $display("FAIL reset_dpc_dcause: got %0d/%h expected 0/0", bus.dcause, bus.dpc);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_haltreq();
    halt_exp_t e;
    bus.haltreq = 1'b1;
    bus.halt_pc = 32'h1000;
    halt_q.push_back('{cause: CAUSE_HALTREQ, pc: 32'h1000});
    tick();
    bus.halt_pc = 32'h1004;
    n_cmp++;
    if ({bus.flush_flag, bus.debug_on, bus.halted} !== 3'b110) begin
      n_mis++; $display("FAIL halt_flush: got %b expected 110",
                        {bus.flush_flag, bus.debug_on, bus.halted});
    end
    tick();
    n_cmp++;
    if ({bus.flush_flag, bus.debug_on, bus.halted} !== 3'b010) begin
      n_mis++; $display("FAIL halt_drain: got %b expected 010",
                        {bus.flush_flag, bus.debug_on, bus.halted});
    end
    tick();
    bus.haltreq = 1'b0;
    n_cmp++;
    if ({bus.halted, bus.running} !== 2'b10) begin
      n_mis++; $display("FAIL halt_latency: got %b expected 10", {bus.halted, bus.running});
    end
    pop_halt(e);
    n_cmp++;
    if ({bus.dcause, bus.dpc} !== e) begin
      n_mis++; $display("FAIL halt_record: got %0d/%h expected %0d/%h",
                        bus.dcause, bus.dpc, e.cause, e.pc);
    end
  endtask

  task automatic test_resume();
    logic [XLEN-1:0] pc;
    bus.dpc_we    = 1'b1;
    bus.dpc_wdata = 32'h200;
    bus.resumereq = 1'b1;
    bus.step_en   = 1'b0;
    redir_q.push_back(32'h200);
    tick();
    bus.dpc_we    = 1'b0;
    bus.resumereq = 1'b0;
    n_cmp++;
    if ({bus.resumeack, bus.redirect_vld, bus.debug_on, bus.halted, bus.running} !== 5'b11000)
    begin
      n_mis++; $display("FAIL resume_pulse: got %b expected 11000", {bus.resumeack,
                        bus.redirect_vld, bus.debug_on, bus.halted, bus.running});
    end
    pc = (redir_q.size() != 0) ? redir_q.pop_front() : '1;
    n_cmp++;
    if (bus.redirect_pc !== pc) begin
      n_mis++; $display("FAIL resume_pc: got %h expected %h", bus.redirect_pc, pc);
    end
    tick();
    n_cmp++;
    if ({bus.running, bus.resumeack, bus.redirect_vld} !== 3'b100) begin
      n_mis++; $display("FAIL resume_running: got %b expected 100",
                        {bus.running, bus.resumeack, bus.redirect_vld});
    end
    bus.dpc_we    = 1'b1;
    bus.dpc_wdata = 32'hdead;
    tick();
    bus.dpc_we = 1'b0;
    n_cmp++;
    if (bus.dpc !== 32'h200) begin
      n_mis++; $display("FAIL dpc_we_ignored: got %h expected 00000200", bus.dpc);
    end
  endtask

  task automatic test_ebreak();
    halt_exp_t e;
    int  cyc;
    bit  ok;
    bus.ebreak_hit = 1'b1;
    bus.haltreq    = 1'b1;
    bus.halt_pc    = 32'h80;
    halt_q.push_back('{cause: CAUSE_EBREAK, pc: 32'h80});
    tick();
    bus.ebreak_hit = 1'b0;
    bus.haltreq    = 1'b0;
    bus.halt_pc    = 32'h0;
    wait_halted(10, cyc, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL ebreak_halted: got halted=0 after %0d cycles expected 1", cyc);
    end
    pop_halt(e);
    n_cmp++;
    if ({bus.dcause, bus.dpc} !== e) begin
      n_mis++; $display("FAIL ebreak_record: got %0d/%h expected %0d/%h",
                        bus.dcause, bus.dpc, e.cause, e.pc);
    end
    do_resume(1'b0);
  endtask

  task automatic test_timeout();
    halt_exp_t e;
    int  cyc;
    bit  ok;
    bus.empty_core = 1'b0;
    bus.haltreq    = 1'b1;
    bus.halt_pc    = 32'h300;
    halt_q.push_back('{cause: CAUSE_HALTREQ, pc: 32'h300});
    tick();
    bus.haltreq = 1'b0;
    n_cmp++;
    if (bus.halt_err !== 1'b0) begin
      n_mis++; $display("FAIL timeout_err_early: got %b expected 0", bus.halt_err);
    end
    wait_halted(80, cyc, ok);
    n_cmp++;
    if (!ok || cyc != DRAIN_TIMEOUT + 1) begin
      n_mis++; $display("FAIL timeout_cycles: got %0d (halted=%b) expected %0d",
                        cyc, bus.halted, DRAIN_TIMEOUT + 1);
    end
    n_cmp++;
    if (bus.halt_err !== 1'b1) begin
      n_mis++; $display("FAIL timeout_err: got %b expected 1", bus.halt_err);
    end
    pop_halt(e);
    n_cmp++;
    if ({bus.dcause, bus.dpc} !== e) begin
      n_mis++; $display("FAIL timeout_record: got %0d/%h expected %0d/%h",
                        bus.dcause, bus.dpc, e.cause, e.pc);
    end
    repeat (4) tick();
    bus.empty_core = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if ({bus.halt_err, bus.halted} !== 2'b11) begin
      n_mis++; $display("FAIL timeout_sticky: got %b expected 11", {bus.halt_err, bus.halted});
    end
  endtask

  task automatic test_step();
    halt_exp_t e;
    int  cyc;
    bit  ok;
    bus.resumereq = 1'b1;
    bus.step_en   = 1'b1;
    tick();
    bus.resumereq = 1'b0;
    bus.step_en   = 1'b0;
    tick();
    n_cmp++;
    if ({bus.running, bus.debug_on, bus.halted} !== 3'b100) begin
      n_mis++; $display("FAIL step_state: got %b expected 100",
                        {bus.running, bus.debug_on, bus.halted});
    end
    repeat (3) tick();
    bus.retire_valid = 1'b1;
    bus.halt_pc      = 32'h204;
    halt_q.push_back('{cause: CAUSE_STEP, pc: 32'h204});
    tick();
    bus.retire_valid = 1'b0;
    bus.halt_pc      = 32'h0;
    n_cmp++;
    if (bus.flush_flag !== 1'b1) begin
      n_mis++; $display("FAIL step_flush: got %b expected 1", bus.flush_flag);
    end
    wait_halted(10, cyc, ok);
    pop_halt(e);
    n_cmp++;
    if (!ok || {bus.dcause, bus.dpc} !== e) begin
      n_mis++; $display("FAIL step_record: got %0d/%h (halted=%b) expected %0d/%h",
                        bus.dcause, bus.dpc, bus.halted, e.cause, e.pc);
    end
    do_resume(1'b1);
    bus.retire_valid = 1'b1;
    bus.ebreak_hit   = 1'b1;
    bus.halt_pc      = 32'h208;
    halt_q.push_back('{cause: CAUSE_EBREAK, pc: 32'h208});
    tick();
    bus.retire_valid = 1'b0;
    bus.ebreak_hit   = 1'b0;
    wait_halted(10, cyc, ok);
    pop_halt(e);
    n_cmp++;
    if (!ok || {bus.dcause, bus.dpc} !== e) begin
      n_mis++; $display("FAIL step_ebreak_record: got %0d/%h (halted=%b) expected %0d/%h",
                        bus.dcause, bus.dpc, bus.halted, e.cause, e.pc);
    end
  endtask

  task automatic test_resume_blocked();
    bus.haltreq   = 1'b1;
    bus.resumereq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.halted, bus.resumeack} !== 2'b10) begin
        n_mis++; $display("FAIL resume_blocked_%0d: got %b expected 10",
                          i, {bus.halted, bus.resumeack});
      end
    end
    bus.haltreq   = 1'b0;
    bus.resumereq = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    halt_exp_t e;
    int  cyc;
    bit  ok;
    bus.resumereq = 1'b1;
    tick();
    bus.resumereq = 1'b0;
    bus.haltreq   = 1'b1;
    bus.halt_pc   = 32'h400;
    halt_q.push_back('{cause: CAUSE_HALTREQ, pc: 32'h400});
    tick();
    n_cmp++;
    if ({bus.running, bus.flush_flag} !== 2'b10) begin
      n_mis++; $display("FAIL b2b_running: got %b expected 10", {bus.running, bus.flush_flag});
    end
    tick();
    bus.haltreq = 1'b0;
    n_cmp++;
    if (bus.flush_flag !== 1'b1) begin
      n_mis++; $display("FAIL b2b_flush: got %b expected 1", bus.flush_flag);
    end
    wait_halted(10, cyc, ok);
    pop_halt(e);
    n_cmp++;
    if (!ok || {bus.dcause, bus.dpc} !== e) begin
      n_mis++; $display("FAIL b2b_record: got %0d/%h (halted=%b) expected %0d/%h",
                        bus.dcause, bus.dpc, bus.halted, e.cause, e.pc);
    end
  endtask

  task automatic test_reset_mid();
    do_resume(1'b0);
    bus.empty_core = 1'b0;
    bus.haltreq    = 1'b1;
    tick();
    bus.haltreq = 1'b0;
    tick();
    n_cmp++;
    if ({bus.debug_on, bus.halt_err, bus.running} !== 3'b110) begin
      n_mis++; $display("FAIL mid_drain: got %b expected 110",
                        {bus.debug_on, bus.halt_err, bus.running});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.empty_core = 1'b1;
    n_cmp++;
    if ({bus.running, bus.debug_on, bus.halt_err, bus.flush_flag} !== 4'b1000) begin
      n_mis++; $display("FAIL mid_reset: got %b expected 1000",
                        {bus.running, bus.debug_on, bus.halt_err, bus.flush_flag});
    end
    tick();
    n_cmp++;
    if ({bus.running, bus.debug_on} !== 2'b10) begin
      n_mis++; $display("FAIL mid_after: got %b expected 10", {bus.running, bus.debug_on});
    end
  endtask

  task automatic test_flush_pulse();
    n_cmp++;
    if (flush_pairs != 0 || halt_q.size() != 0) begin
      n_mis++; $display("FAIL flush_single: got pairs=%0d pending=%0d expected 0/0",
                        flush_pairs, halt_q.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_haltreq();
    test_resume();
    test_ebreak();
    test_timeout();
    test_step();
    test_resume_blocked();
    test_back_to_back();
    test_reset_mid();
    test_flush_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
